// File: rtl/alu_unit.sv
// alu_unit: RV32I integer ALU for the execute stage.
// Operand A is r1 or pc, operand B is r2 or the immediate. The result,
// its zero flag and a valid strobe are registered: one cycle of latency
// and one operation per cycle.
// Optional build macro ALU_MUL_EN adds the RV32M multiply codes 11-14.
// Without it, codes 11-15 return 0 and no multiplier is built.
module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      alucode,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            using_r2,
  input  logic            using_pc,
  output logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  output logic            result_zero
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SLT    = 4'd2;
  localparam logic [3:0] OP_SLTU   = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_AND    = 4'd6;
  localparam logic [3:0] OP_SLL    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SRA    = 4'd9;
  localparam logic [3:0] OP_PASSB  = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL    = 4'd11;
  localparam logic [3:0] OP_MULH   = 4'd12;
  localparam logic [3:0] OP_MULHSU = 4'd13;
  localparam logic [3:0] OP_MULHU  = 4'd14;
`endif

  // Stage p0: operand selection and combinational result
  logic        [XLEN-1:0] opa_p0;
  logic        [XLEN-1:0] opb_p0;
  logic signed [XLEN-1:0] opa_s_p0;
  logic signed [XLEN-1:0] opb_s_p0;
  logic        [SHW-1:0]  shamt_p0;
  logic        [XLEN-1:0] res_p0;

  assign opa_p0   = using_pc ? pc : r1;
  assign opb_p0   = using_r2 ? r2 : imm;
  assign opa_s_p0 = opa_p0;
  assign opb_s_p0 = opb_p0;
  // Only the low log2(XLEN) bits of B are a shift amount; the rest is ignored.
  assign shamt_p0 = opb_p0[SHW-1:0];

`ifdef ALU_MUL_EN
  // A single 64-bit multiplier serves all four codes. Each operand is sign-
  // or zero-extended to 2*XLEN according to the code, so the low 2*XLEN bits
  // of the product hold both the low word and the correct high word.
  logic [2*XLEN-1:0] mula_p0;
  logic [2*XLEN-1:0] mulb_p0;
  logic [2*XLEN-1:0] prod_p0;
  logic              sgna_p0;
  logic              sgnb_p0;

  // Pick operand signedness for MULH (s*s) and MULHSU (s*u); all else unsigned
  always_comb begin
    sgna_p0 = (alucode == OP_MULH) || (alucode == OP_MULHSU);
    sgnb_p0 = (alucode == OP_MULH);
    mula_p0 = {{XLEN{sgna_p0 & opa_p0[XLEN-1]}}, opa_p0};
    mulb_p0 = {{XLEN{sgnb_p0 & opb_p0[XLEN-1]}}, opb_p0};
    prod_p0 = mula_p0 * mulb_p0;
  end
`endif

  // Decode alucode into the combinational result; reserved codes yield 0
  always_comb begin
    res_p0 = '0;
    case (alucode)
      OP_ADD:    res_p0 = opa_p0 + opb_p0;
      OP_SUB:    res_p0 = opa_p0 - opb_p0;
      OP_SLT:    res_p0 = {{(XLEN-1){1'b0}}, (opa_s_p0 < opb_s_p0)};
      OP_SLTU:   res_p0 = {{(XLEN-1){1'b0}}, (opa_p0 < opb_p0)};
      OP_XOR:    res_p0 = opa_p0 ^ opb_p0;
      OP_OR:     res_p0 = opa_p0 | opb_p0;
      OP_AND:    res_p0 = opa_p0 & opb_p0;
      OP_SLL:    res_p0 = opa_p0 << shamt_p0;
      OP_SRL:    res_p0 = opa_p0 >> shamt_p0;
      OP_SRA:    res_p0 = opa_s_p0 >>> shamt_p0;
      OP_PASSB:  res_p0 = opb_p0;
`ifdef ALU_MUL_EN
      OP_MUL:    res_p0 = prod_p0[XLEN-1:0];
      OP_MULH:   res_p0 = prod_p0[2*XLEN-1:XLEN];
      OP_MULHSU: res_p0 = prod_p0[2*XLEN-1:XLEN];
      OP_MULHU:  res_p0 = prod_p0[2*XLEN-1:XLEN];
`endif
      default:   res_p0 = '0;
    endcase
  end

  // Stage p1: registered result, zero flag and valid
  logic [XLEN-1:0] result_p1;
  logic            zero_p1;
  logic            vld_p1;

  // Capture on accepted requests; idle cycles drop valid but hold the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b1;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        result_p1 <= res_p0;
        zero_p1   <= (res_p0 == '0);
      end
    end
  end

  assign alu_result  = result_p1;
  assign result_zero = zero_p1;
  assign out_valid   = vld_p1;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed self-checking bench for alu_unit.
// Inputs change 1 time unit after a rising edge. Outputs are sampled
// 1 time unit after the edge that captures them.
`timescale 1ns/1ps
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  alucode;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        using_r2;
  logic        using_pc;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        result_zero;

  int checks = 0;
  int errors = 0;

  alu_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .alucode    (alucode),
    .r1         (r1),
    .r2         (r2),
    .pc         (pc),
    .imm        (imm),
    .using_r2   (using_r2),
    .using_pc   (using_pc),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .result_zero(result_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected to end earlier", $time);
    $fatal(1, "timeout");
  end

  // Drive a register-register operation (A=r1, B=r2).
  task automatic drive_rr(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alucode  = code;
    r1       = a;
    r2       = b;
    using_r2 = 1'b1;
    using_pc = 1'b0;
    pc       = 32'hA5A5_0000;
    imm      = 32'h5A5A_0000;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (alu_result !== 32'd0 || out_valid !== 1'b0 || result_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_initial: got result=%h valid=%b zero=%b, expected result=00000000 valid=0 zero=1",
               alu_result, out_valid, result_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_rr(4'd0, 32'd7, 32'd8);
    @(posedge clk); #1;
    checks++;
    if (alu_result !== 32'd15 || out_valid !== 1'b1 || result_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_capture: got result=%h valid=%b zero=%b, expected result=0000000f valid=1 zero=0",
               alu_result, out_valid, result_zero);
    end
    // Assert reset between edges with a request still pending.
    drive_rr(4'd0, 32'd100, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (alu_result !== 32'd0 || out_valid !== 1'b0 || result_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got result=%h valid=%b zero=%b, expected result=00000000 valid=0 zero=1",
               alu_result, out_valid, result_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (alu_result !== 32'd0 || out_valid !== 1'b0 || result_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_held_edge: got result=%h valid=%b zero=%b, expected result=00000000 valid=0 zero=1",
               alu_result, out_valid, result_zero);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [3:0]  c [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [31:0] a [4] = '{32'd34, 32'd55, 32'hFEEDFACE, 32'hBADCAB1E};
    logic [31:0] b [4] = '{32'd55, 32'd56, 32'hBADCAB1E, 32'hFEEDFACE};
    logic [31:0] e [4] = '{32'd89, 32'hFFFFFFFF, 32'd0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      drive_rr(c[i], a[i], b[i]);
      @(posedge clk); #1;
      checks++;
      if (alu_result !== e[i] || out_valid !== 1'b1 || result_zero !== (e[i] == 32'd0)) begin
        errors++;
        $display("FAIL arith[%0d]: got result=%h valid=%b zero=%b, expected result=%h valid=1 zero=%b",
                 i, alu_result, out_valid, result_zero, e[i], (e[i] == 32'd0));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_logic();
    logic [3:0]  c [3] = '{4'd5, 4'd6, 4'd4};
    logic [31:0] a [3] = '{32'hBADCAB1E, 32'hBADCAB1E, 32'hBADCAB1F};
    logic [31:0] e [3] = '{32'hFEFDFBDE, 32'hBACCAA0E, 32'h443151D1};
    for (int i = 0; i < 3; i++) begin
      drive_rr(c[i], a[i], 32'hFEEDFACE);
      @(posedge clk); #1;
      checks++;
      if (alu_result !== e[i] || out_valid !== 1'b1 || result_zero !== 1'b0) begin
        errors++;
        $display("FAIL logic[%0d]: got result=%h valid=%b zero=%b, expected result=%h valid=1 zero=0",
                 i, alu_result, out_valid, result_zero, e[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_shift();
    logic [3:0]  c [7] = '{4'd7, 4'd8, 4'd9, 4'd9, 4'd8, 4'd7, 4'd9};
    logic [31:0] a [7] = '{32'hFEEDFACE, 32'hDEADDEAD, 32'hDEADDEAD, 32'h80000000,
                           32'h80000000, 32'h00000001, 32'h7000000F};
    logic [31:0] b [7] = '{32'd1036, 32'd16, 32'd16, 32'd31, 32'd31, 32'd32, 32'd4};
    logic [31:0] e [7] = '{32'hDFACE000, 32'h0000DEAD, 32'hFFFFDEAD, 32'hFFFFFFFF,
                           32'h00000001, 32'h00000001, 32'h07000000};
    for (int i = 0; i < 7; i++) begin
      drive_rr(c[i], a[i], b[i]);
      @(posedge clk); #1;
      checks++;
      if (alu_result !== e[i] || out_valid !== 1'b1 || result_zero !== 1'b0) begin
        errors++;
        $display("FAIL shift[%0d]: got result=%h valid=%b zero=%b, expected result=%h valid=1 zero=0",
                 i, alu_result, out_valid, result_zero, e[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mux();
    logic [3:0]  c   [4] = '{4'd0, 4'd10, 4'd1, 4'd10};
    logic        upc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        ur2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] va1 [4] = '{32'hDEAD0000, 32'h11111111, 32'd5, 32'h22222222};
    logic [31:0] va2 [4] = '{32'hBEEF0000, 32'h33333333, 32'd5, 32'hCAFEF00D};
    logic [31:0] vpc [4] = '{32'h00000100, 32'h44444444, 32'h55555555, 32'h66666666};
    logic [31:0] vim [4] = '{32'd4, 32'h12345000, 32'h77777777, 32'h88888888};
    logic [31:0] e   [4] = '{32'h00000104, 32'h12345000, 32'd0, 32'hCAFEF00D};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      alucode  = c[i];
      using_pc = upc[i];
      using_r2 = ur2[i];
      r1       = va1[i];
      r2       = va2[i];
      pc       = vpc[i];
      imm      = vim[i];
      @(posedge clk); #1;
      checks++;
      if (alu_result !== e[i] || out_valid !== 1'b1 || result_zero !== (e[i] == 32'd0)) begin
        errors++;
        $display("FAIL mux[%0d]: got result=%h valid=%b zero=%b, expected result=%h valid=1 zero=%b",
                 i, alu_result, out_valid, result_zero, e[i], (e[i] == 32'd0));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c [6] = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd6, 4'd5};
    logic [31:0] a [6] = '{32'd1, 32'd10, 32'h000000F0, 32'd1, 32'hFFFF0000, 32'h00000100};
    logic [31:0] b [6] = '{32'd2, 32'd3, 32'h0000000F, 32'd4, 32'h0000FFFF, 32'h00000001};
    logic [31:0] e [6] = '{32'd3, 32'd7, 32'h000000FF, 32'd16, 32'd0, 32'h00000101};
    for (int i = 0; i < 6; i++) begin
      drive_rr(c[i], a[i], b[i]);
      @(posedge clk); #1;
      checks++;
      if (alu_result !== e[i] || out_valid !== 1'b1 || result_zero !== (e[i] == 32'd0)) begin
        errors++;
        $display("FAIL b2b[%0d]: got result=%h valid=%b zero=%b, expected result=%h valid=1 zero=%b",
                 i, alu_result, out_valid, result_zero, e[i], (e[i] == 32'd0));
      end
    end
  endtask

  task automatic test_hold();
    // Request dropped with different inputs present: outputs must hold 0x101.
    in_valid = 1'b0;
    drive_rr(4'd1, 32'd9, 32'd9);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_result !== 32'h00000101 || out_valid !== 1'b0 || result_zero !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got result=%h valid=%b zero=%b, expected result=00000101 valid=0 zero=0",
               alu_result, out_valid, result_zero);
    end
    // Zero result, then an idle cycle: the zero flag must hold as well.
    drive_rr(4'd1, 32'd9, 32'd9);
    @(posedge clk); #1;
    drive_rr(4'd0, 32'd1, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_result !== 32'd0 || out_valid !== 1'b0 || result_zero !== 1'b1) begin
      errors++;
      $display("FAIL hold_zero: got result=%h valid=%b zero=%b, expected result=00000000 valid=0 zero=1",
               alu_result, out_valid, result_zero);
    end
    // Input changes between edges must not disturb the held output.
    r1 = 32'h12345678;
    #2;
    checks++;
    if (alu_result !== 32'd0 || result_zero !== 1'b1) begin
      errors++;
      $display("FAIL hold_midcycle: got result=%h zero=%b, expected result=00000000 zero=1",
               alu_result, result_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved();
`ifdef ALU_MUL_EN
    logic [3:0]  c [5] = '{4'd15, 4'd14, 4'd11, 4'd12, 4'd13};
    logic [31:0] e [5] = '{32'd0, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
`else
    logic [3:0]  c [5] = '{4'd15, 4'd14, 4'd11, 4'd12, 4'd13};
    logic [31:0] e [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
    for (int i = 0; i < 5; i++) begin
      // Preload a non-zero result so a zero answer is a real change.
      drive_rr(4'd0, 32'd40, 32'd2);
      @(posedge clk); #1;
      drive_rr(c[i], 32'hFFFFFFFF, 32'hFFFFFFFF);
      @(posedge clk); #1;
      checks++;
      if (alu_result !== e[i] || out_valid !== 1'b1 || result_zero !== (e[i] == 32'd0)) begin
        errors++;
        $display("FAIL code%0d: got result=%h valid=%b zero=%b, expected result=%h valid=1 zero=%b",
                 c[i], alu_result, out_valid, result_zero, e[i], (e[i] == 32'd0));
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    alucode  = 4'd0;
    r1       = 32'd0;
    r2       = 32'd0;
    pc       = 32'd0;
    imm      = 32'd0;
    using_r2 = 1'b1;
    using_pc = 1'b0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mux();
    test_back_to_back();
    test_hold();
    test_reserved();
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Integer ALU for the RV32I execute stage.
- Selects operands from register, PC or immediate sources, then performs add/sub, signed and unsigned compare, logic ops and shifts.
- Result is registered: one-cycle latency with a valid strobe.
- Sits between decode/operand fetch and the writeback/branch logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; shift amount is log2(XLEN)=5 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request this cycle.
- alucode  input  4  operation select (encoding below).
- r1  input  32  register source 1.
- r2  input  32  register source 2.
- pc  input  32  program counter of the instruction.
- imm  input  32  sign-extended immediate.
- using_r2  input  1  1: operand B = r2; 0: operand B = imm.
- using_pc  input  1  1: operand A = pc; 0: operand A = r1.
- alu_result  output  32  registered result.
- out_valid  output  1  alu_result holds a new result this cycle.
- result_zero  output  1  registered flag, 1 when alu_result == 0.

Behaviour:
- Operand selection:
  - A = using_pc ? pc : r1.
  - B = using_r2 ? r2 : imm.
- alucode encoding (4'd):
  - 0 ADD: A+B, modulo 2^32.
  - 1 SUB: A-B, modulo 2^32.
  - 2 SLT: signed A<B gives 1, else 0.
  - 3 SLTU: unsigned A<B gives 1, else 0.
  - 4 XOR: A^B.
  - 5 OR: A|B.
  - 6 AND: A&B.
  - 7 SLL: A << B[4:0].
  - 8 SRL: logical A >> B[4:0].
  - 9 SRA: arithmetic A >>> B[4:0], sign-filled.
  - 10 PASSB: result = B (used for LUI).
  - 11-15: reserved; result 0 unless the optional feature is compiled in.
- Shift amount: only B[4:0] is used; B[31:5] is ignored (e.g. 1036 shifts by 12).
- Overflow and carry are discarded; no exceptions are raised.
- Timing:
  - On the rising clk edge with in_valid=1: alu_result, result_zero and out_valid=1 are loaded from the current inputs.
  - Latency is exactly 1 cycle; throughput is 1 operation per cycle.
  - No backpressure.
- With in_valid=0 at an edge: out_valid goes 0; alu_result and result_zero hold their previous values.
- Reset:
  - While rst is high, asynchronously: alu_result=0, result_zero=1, out_valid=0.
  - The first capture occurs on the first rising edge after rst deasserts, if in_valid=1.
  - Reset asserted mid-stream discards the in-flight result immediately.
- Inputs are sampled only at the edge; changes between edges have no effect.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: alucodes 11-14 implement RV32M multiply. Still 1-cycle registered latency.
  - 11 MUL: low 32 bits of A*B.
  - 12 MULH: high 32 bits, signed×signed.
  - 13 MULHSU: high 32 bits, signed A × unsigned B.
  - 14 MULHU: high 32 bits, unsigned×unsigned.
  - 15 remains reserved and returns 0.
- Undefined: codes 11-15 return 0 and no multiplier hardware is instantiated.

Test Plan:
- Reset: hold rst high mid-operation -> alu_result=0, out_valid=0, result_zero=1 immediately, without waiting for a clock edge.
- Arithmetic, using_r2=1, using_pc=0, in_valid=1; each result appears 1 cycle later with out_valid=1:
  - ADD 34+55 -> 89.
  - SUB 55-56 -> 0xFFFFFFFF.
  - SLT 0xFEEDFACE vs 0xBADCAB1E -> 0.
  - SLTU 0xBADCAB1E vs 0xFEEDFACE -> 1.
- Logic, A=0xBADCAB1E / B=0xFEEDFACE:
  - OR -> 0xFEFDFBDE.
  - AND -> 0xBACCAA0E.
  - XOR with A=0xBADCAB1F -> 0x443151D1.
- Shifts:
  - SLL 0xFEEDFACE by 1036 -> 0xDFACE000.
  - SRL 0xDEADDEAD by 16 -> 0x0000DEAD.
  - SRA 0xDEADDEAD by 16 -> 0xFFFFDEAD.
- Operand muxing:
  - using_pc=1, pc=0x100, using_r2=0, imm=4, ADD -> 0x104.
  - PASSB with imm=0x12345000 -> 0x12345000.
  - SUB 5-5 -> result 0 with result_zero=1.
- Streaming and reserved code:
  - Back-to-back ops every cycle -> a new result every cycle, in order.
  - Drop in_valid for one cycle -> out_valid=0 and alu_result holds.
  - alucode 15 -> 0.
  - With ALU_MUL_EN defined: MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE, MUL -> 0x00000001.
